// File: rtl/gpu_ram_port_scheduler.sv
// Pixel-phase generator and round-robin scheduler sharing one RAM read port
// between three tagged requesters; returns are routed back by tag.
module gpu_ram_port_scheduler #(
  parameter int unsigned PC_DIV    = 4,
  parameter int unsigned ADDR_SIZE = 20,
  parameter int unsigned RET_PHASE = 0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 sched_ena,
  output logic [3:0]           pc_ena,
  input  logic [2:0]           req,
  input  logic [ADDR_SIZE-1:0] req_addr0,
  input  logic [ADDR_SIZE-1:0] req_addr1,
  input  logic [ADDR_SIZE-1:0] req_addr2,
  output logic [2:0]           ack,
  output logic [ADDR_SIZE-1:0] ram_addr,
  output logic [15:0]          ram_cmd,
  input  logic [15:0]          ram_cmd_ret,
  input  logic [7:0]           ram_data_ret,
  output logic [2:0]           rd_valid,
  output logic [7:0]           rd_data,
  output logic                 tag_err
);

  localparam logic [3:0] LAST_PHASE = 4'(PC_DIV - 1);
  localparam logic [3:0] RET_CNT    = 4'(RET_PHASE);

  logic [3:0]           pc_cnt;
  logic [1:0]           rr_ptr;
  logic                 slot;
  logic                 ret_slot;
  logic                 win_vld;
  logic [1:0]           win_id;
  logic [1:0]           rr_next;
  logic [ADDR_SIZE-1:0] win_addr;
  logic [1:0]           ret_id;

  assign pc_ena   = pc_cnt;
  assign slot     = (pc_cnt == LAST_PHASE);
  assign ret_slot = (pc_cnt == RET_CNT);
  assign ret_id   = ram_cmd_ret[1:0];
  assign rr_next  = (win_id == 2'd2) ? 2'd0 : win_id + 2'd1;

  // First requesting index found walking rr_ptr, rr_ptr+1, rr_ptr+2 modulo 3.
  always_comb begin
    logic [2:0] sum;
    logic [1:0] idx;
    win_vld = 1'b0;
    win_id  = '0;
    sum     = '0;
    idx     = '0;
    for (int unsigned k = 0; k < 3; k++) begin
      sum = {1'b0, rr_ptr} + 3'(k);
      idx = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
      if (!win_vld && req[idx]) begin
        win_vld = 1'b1;
        win_id  = idx;
      end
    end
  end

  always_comb begin
    case (win_id)
      2'd1:    win_addr = req_addr1;
      2'd2:    win_addr = req_addr2;
      default: win_addr = req_addr0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_cnt   <= '0;
      rr_ptr   <= '0;
      ack      <= '0;
      ram_addr <= '0;
      ram_cmd  <= '0;
      rd_valid <= '0;
      rd_data  <= '0;
      tag_err  <= 1'b0;
    end else begin
      pc_cnt <= slot ? 4'd0 : pc_cnt + 4'd1;

      ack <= '0;
      if (slot) begin
        if (sched_ena && win_vld) begin
          ram_addr <= win_addr;
          ram_cmd  <= {1'b1, 13'b0, win_id};
          ack      <= 3'b001 << win_id;
          rr_ptr   <= rr_next;
        end else begin
          ram_cmd <= '0;
        end
      end

      rd_valid <= '0;
      if (ret_slot && ram_cmd_ret[15]) begin
        if (ret_id == 2'd3) begin
          tag_err <= 1'b1;
        end else begin
          rd_valid <= 3'b001 << ret_id;
          rd_data  <= ram_data_ret;
        end
      end
    end
  end

endmodule
